key_debounce_bank: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_ch.sv | 121 ++++++++++++
 rtl/key_debounce_bank.sv | 42 ++++
 tb/tb_key_debounce_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the key debounce bank.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_REPEAT
  } rep_state_t;

  // Bits needed to count 0 .. max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability filter, level and edge pulses.
// With KEY_REPEAT_EN defined, a typematic FSM re-issues press pulses while held.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYC    = 1000000,
  parameter logic        IDLE_LEVEL    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int SW = cnt_width(STABLE_CYC);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic          press_q, release_q;
  logic          press_edge, release_edge;

  // The counter only ever reaches STABLE_LAST; at that point the level flips instead.
  always_comb begin
    stab_cnt_d = '0;
    level_d    = level_q;
    if (sync2_q != level_q) begin
      if (stab_cnt_q == STABLE_LAST) begin
        level_d = sync2_q;
      end else begin
        stab_cnt_d = stab_cnt_q + 1'b1;
      end
    end
  end

  assign press_edge   = (level_d != level_q) && (level_d != IDLE_LEVEL);
  assign release_edge = (level_d != level_q) && (level_d == IDLE_LEVEL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= IDLE_LEVEL;
      sync2_q    <= IDLE_LEVEL;
      level_q    <= IDLE_LEVEL;
      stab_cnt_q <= '0;
      release_q  <= 1'b0;
    end else begin
      sync1_q    <= in_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      stab_cnt_q <= stab_cnt_d;
      release_q  <= release_edge;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_width(REP_MAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  rep_state_t    rep_state_q;
  logic [RW-1:0] rep_cnt_q;
  logic          rep_fire;

  assign rep_fire = ((rep_state_q == REP_DELAY)  && (rep_cnt_q == DELAY_LAST)) ||
                    ((rep_state_q == REP_REPEAT) && (rep_cnt_q == PERIOD_LAST));

  // A release landing on a scheduled repeat suppresses that repeat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_state_q <= REP_IDLE;
      rep_cnt_q   <= '0;
      press_q     <= 1'b0;
    end else begin
      press_q <= press_edge || (rep_fire && !release_edge);
      if (press_edge) begin
        rep_state_q <= REP_DELAY;
        rep_cnt_q   <= '0;
      end else if (release_edge) begin
        rep_state_q <= REP_IDLE;
        rep_cnt_q   <= '0;
      end else begin
        case (rep_state_q)
          REP_DELAY: begin
            if (rep_cnt_q == DELAY_LAST) begin
              rep_state_q <= REP_REPEAT;
              rep_cnt_q   <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
          REP_REPEAT: begin
            if (rep_cnt_q == PERIOD_LAST) rep_cnt_q <= '0;
            else                          rep_cnt_q <= rep_cnt_q + 1'b1;
          end
          default: begin
            rep_state_q <= REP_IDLE;
            rep_cnt_q   <= '0;
          end
        endcase
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) press_q <= 1'b0;
    else       press_q <= press_edge;
  end
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce_bank.sv
// N_CH independent debounce channels plus an any-press summary.
// Define KEY_REPEAT_EN to build typematic auto-repeat into every channel.
module key_debounce_bank
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 8,
  parameter int unsigned STABLE_CYC    = 1000000,
  parameter logic        IDLE_LEVEL    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic            o_any_press
);

  genvar gi;
  generate
    for (gi = 0; gi < int'(N_CH); gi++) begin : g_ch
      key_debounce_ch #(
        .STABLE_CYC   (STABLE_CYC),
        .IDLE_LEVEL   (IDLE_LEVEL),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .in_i     (i_in[gi]),
        .level_o  (o_level[gi]),
        .press_o  (o_press[gi]),
        .release_o(o_release[gi])
      );
    end
  endgenerate

  assign o_any_press = |o_press;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench: a run-length reference model predicts pulse events, a monitor checks them.
module tb_key_debounce_bank;

  localparam int   N_CH   = 4;
  localparam int   STABLE = 4;
  localparam logic IDLE   = 1'b1;
  localparam int   DELAY  = 10;
  localparam int   PERIOD = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] in_w;
  logic [N_CH-1:0] level_w, press_w, release_w;
  logic            any_w;

  key_debounce_bank #(
    .N_CH(N_CH), .STABLE_CYC(STABLE), .IDLE_LEVEL(IDLE),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_in(in_w),
    .o_level(level_w), .o_press(press_w), .o_release(release_w),
    .o_any_press(any_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] level;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  task automatic check(input string name, input logic [N_CH-1:0] act,
                       input logic [N_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the level follows the twice-delayed input once it has
  // disagreed with the level for STABLE consecutive cycles.
  logic [N_CH-1:0] m_s1, m_s2, m_level;
  int              m_run[N_CH];
`ifdef KEY_REPEAT_EN
  int              m_press_cyc[N_CH];
`endif

  always @(posedge clk) begin : model
    logic [N_CH-1:0] p, r;
`ifdef KEY_REPEAT_EN
    int age;
`endif
    cyc++;
    p = '0;
    r = '0;
    if (rst) begin
      m_s1    = {N_CH{IDLE}};
      m_s2    = {N_CH{IDLE}};
      m_level = {N_CH{IDLE}};
      for (int ch = 0; ch < N_CH; ch++) begin
        m_run[ch] = 0;
`ifdef KEY_REPEAT_EN
        m_press_cyc[ch] = -1;
`endif
      end
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (m_s2[ch] != m_level[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == STABLE) begin
            m_level[ch] = m_s2[ch];
            m_run[ch]   = 0;
            if (m_level[ch] != IDLE) begin
              p[ch] = 1'b1;
`ifdef KEY_REPEAT_EN
              m_press_cyc[ch] = cyc;
`endif
            end else begin
              r[ch] = 1'b1;
`ifdef KEY_REPEAT_EN
              m_press_cyc[ch] = -1;
`endif
            end
          end
        end else begin
          m_run[ch] = 0;
        end
`ifdef KEY_REPEAT_EN
        if (!p[ch] && m_level[ch] != IDLE && m_press_cyc[ch] >= 0) begin
          age = cyc - m_press_cyc[ch];
          if (age == DELAY || (age > DELAY && (age - DELAY) % PERIOD == 0)) p[ch] = 1'b1;
        end
`endif
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = in_w[ch];
      end
      if ((p | r) != '0) exp_q.push_back('{cyc: cyc, press: p, rel: r, level: m_level});
    end
  end

  // Monitor: every expected event must appear at its edge; any other pulse is spurious.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("press", press_w, e.press);
      check("release", release_w, e.rel);
      check("level_at_event", level_w, e.level);
      check("any_press", {{(N_CH-1){1'b0}}, any_w}, {{(N_CH-1){1'b0}}, |e.press});
    end else if (press_w != '0 || release_w != '0) begin
      check("unexpected_pulse", press_w | release_w, '0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hold[N_CH];

  initial begin
    rst  = 1'b1;
    in_w = 4'h0;
    repeat (3) begin
      @(negedge clk);
      check("reset_level", level_w, 4'hF);
      check("reset_press", press_w, 4'h0);
      check("reset_release", release_w, 4'h0);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_level", level_w, 4'hF);
      check("post_reset_pulses", press_w | release_w, 4'h0);
    end
    wait_cyc(3);
    in_w = 4'hF;
    wait_cyc(12);

    // Clean press and release on channel 0.
    in_w[0] = 1'b0; wait_cyc(10);
    check("ch0_held_level", level_w, 4'hE);
    in_w[0] = 1'b1; wait_cyc(10);

    // Short glitch on channel 1 is swallowed.
    in_w[1] = 1'b0; wait_cyc(3);
    in_w[1] = 1'b1; wait_cyc(10);
    check("glitch_level", level_w, 4'hF);

    // Bounce 0,0,1,0,0,0,0 then held low.
    foreach (hold[i]) hold[i] = 0;
    in_w[1] = 1'b0; wait_cyc(2);
    in_w[1] = 1'b1; wait_cyc(1);
    in_w[1] = 1'b0; wait_cyc(14);
    in_w[1] = 1'b1; wait_cyc(10);

    // Simultaneous press on channels 2 and 3.
    in_w[3:2] = 2'b00; wait_cyc(10);
    in_w[3:2] = 2'b11; wait_cyc(10);

    // Reset while channel 0 is mid-count.
    in_w[0] = 1'b0; wait_cyc(4);
    rst = 1'b1; wait_cyc(1);
    check("midcount_reset_level", level_w, 4'hF);
    rst = 1'b0; wait_cyc(10);
    in_w[0] = 1'b1; wait_cyc(10);

    // Long hold on channel 0; release lands on a would-be repeat edge.
    in_w[0] = 1'b0; wait_cyc(45);
    in_w[0] = 1'b1; wait_cyc(15);

    // Randomised bouncy traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        if (hold[ch] == 0) begin
          in_w[ch] = 1'($urandom_range(0, 1));
          hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                  : int'($urandom_range(4, 40));
        end else begin
          hold[ch]--;
        end
      end
    end

    rst  = 1'b0;
    in_w = 4'hF;
    wait_cyc(20);
    check("final_level", level_w, 4'hF);
    check("final_queue_empty", N_CH'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
